// File: rtl/dpram_access_ctrl.sv
// dpram_access_ctrl
//   Access controller in front of a DEPTH x DATA_W dual-port RAM with registered
//   read data. After reset it clears the array two words per cycle (INIT). It
//   then serves two clients, A and B, each on its own RAM port (RUN). When both
//   clients hit the same address and at least one writes, only the client named
//   by the alternating priority bit is acked. The priority then flips to the
//   loser, so under persistent conflict the two clients take turns.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   req_x, we_x, addr_x,     client x request (held until ack_x), write enable,
//   wdata_x                  address, write data
//   ack_x                    combinational accept for this cycle
//   rvalid_x, rdata_x        read data valid (registered) / RAM read data
//   busy                     high while the array is being cleared
//   coll_cnt                 saturating collision count
//   ram_we_x, ram_addr_x,    RAM port x drive
//   ram_din_x, ram_dout_x    RAM port x write data / registered read data
module dpram_access_ctrl #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_a,
    input  logic              req_b,
    input  logic              we_a,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata_a,
    input  logic [DATA_W-1:0] wdata_b,
    output logic              ack_a,
    output logic              ack_b,
    output logic              rvalid_a,
    output logic              rvalid_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    output logic              busy,
    output logic [7:0]        coll_cnt,
    output logic              ram_we_a,
    output logic              ram_we_b,
    output logic [ADDR_W-1:0] ram_addr_a,
    output logic [ADDR_W-1:0] ram_addr_b,
    output logic [DATA_W-1:0] ram_din_a,
    output logic [DATA_W-1:0] ram_din_b,
    input  logic [DATA_W-1:0] ram_dout_a,
    input  logic [DATA_W-1:0] ram_dout_b
);

    typedef enum logic {ST_INIT, ST_RUN} state_e;

    // The clear walks word pairs, so the counter is one bit narrower than the
    // address; its all-ones value marks the last pair.
    localparam logic [ADDR_W-2:0] INIT_LAST = '1;

    state_e              state_q;
    logic [ADDR_W-2:0]   init_cnt_q;
    logic                pri_q;        // 0: A wins the next collision, 1: B
    logic [7:0]          coll_cnt_q;
    logic [7:0]          coll_cnt_d;
    logic                rvalid_a_q, rvalid_b_q;
    logic                rvalid_a_d, rvalid_b_d;
    logic                run;
    logic                coll;

    assign run  = (state_q == ST_RUN);
    assign coll = req_a & req_b & (addr_a == addr_b) & (we_a | we_b);

    // Without a collision both requests go through; with one, only the
    // priority holder does. Nothing is acked while the array is being cleared.
    assign ack_a = run & req_a & (~coll | ~pri_q);
    assign ack_b = run & req_b & (~coll |  pri_q);

    assign rvalid_a_d = ack_a & ~we_a;
    assign rvalid_b_d = ack_b & ~we_b;
    assign coll_cnt_d = (coll_cnt_q == 8'hFF) ? coll_cnt_q : coll_cnt_q + 8'd1;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        ram_we_a   = 1'b0;
        ram_we_b   = 1'b0;
        ram_addr_a = '0;
        ram_addr_b = '0;
        ram_din_a  = '0;
        ram_din_b  = '0;
        if (!run) begin
            // Clearing: port A takes the even word, port B the odd word. This
            // is also what the RAM sees while rst is held.
            ram_we_a   = 1'b1;
            ram_we_b   = 1'b1;
            ram_addr_a = {init_cnt_q, 1'b0};
            ram_addr_b = {init_cnt_q, 1'b1};
        end else begin
            if (ack_a) begin
                ram_we_a   = we_a;
                ram_addr_a = addr_a;
                ram_din_a  = wdata_a;
            end
            if (ack_b) begin
                ram_we_b   = we_b;
                ram_addr_b = addr_b;
                ram_din_b  = wdata_b;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
            pri_q      <= 1'b0;
            coll_cnt_q <= '0;
            rvalid_a_q <= 1'b0;
            rvalid_b_q <= 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    init_cnt_q <= init_cnt_q + 1'b1;
                    rvalid_a_q <= 1'b0;
                    rvalid_b_q <= 1'b0;
                    if (init_cnt_q == INIT_LAST) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    rvalid_a_q <= rvalid_a_d;
                    rvalid_b_q <= rvalid_b_d;
                    if (coll) begin
                        pri_q      <= ~pri_q;
                        coll_cnt_q <= coll_cnt_d;
                    end
                end
                default: state_q <= ST_INIT;
            endcase
        end
    end

    assign busy     = ~run;
    assign coll_cnt = coll_cnt_q;
    assign rvalid_a = rvalid_a_q;
    assign rvalid_b = rvalid_b_q;
    assign rdata_a  = ram_dout_a;
    assign rdata_b  = ram_dout_b;

endmodule

// File: tb/tb_dpram_access_ctrl.sv
// Testbench for dpram_access_ctrl: drives both clients cycle by cycle with a
// behavioural dual-port RAM attached. Read results expected by the bench are
// queued when a read is acked and compared when rvalid comes back.
module tb_dpram_access_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_a, req_b, we_a, we_b;
    logic [2:0] addr_a, addr_b;
    logic [7:0] wdata_a, wdata_b;
    logic       ack_a, ack_b, rvalid_a, rvalid_b, busy;
    logic [7:0] rdata_a, rdata_b, coll_cnt;
    logic       ram_we_a, ram_we_b;
    logic [2:0] ram_addr_a, ram_addr_b;
    logic [7:0] ram_din_a, ram_din_b, ram_dout_a, ram_dout_b;

    always #5 clk = ~clk;

    dpram_access_ctrl #(.ADDR_W(3), .DATA_W(8)) dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
        .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
        .ack_a(ack_a), .ack_b(ack_b), .rvalid_a(rvalid_a), .rvalid_b(rvalid_b),
        .rdata_a(rdata_a), .rdata_b(rdata_b), .busy(busy), .coll_cnt(coll_cnt),
        .ram_we_a(ram_we_a), .ram_we_b(ram_we_b),
        .ram_addr_a(ram_addr_a), .ram_addr_b(ram_addr_b),
        .ram_din_a(ram_din_a), .ram_din_b(ram_din_b),
        .ram_dout_a(ram_dout_a), .ram_dout_b(ram_dout_b)
    );

    // Behavioural 8x8 dual-port RAM: registered read, output held on write.
    logic [7:0] mem [8];
    initial for (int i = 0; i < 8; i++) mem[i] = 8'hFF;
    always @(posedge clk) begin
        if (ram_we_a) mem[ram_addr_a] <= ram_din_a;
        else          ram_dout_a <= mem[ram_addr_a];
        if (ram_we_b) mem[ram_addr_b] <= ram_din_b;
        else          ram_dout_b <= mem[ram_addr_b];
    end

    // Reference contents and read scoreboards.
    logic [7:0] ref_mem [8];
    logic [7:0] q_a [$];
    logic [7:0] q_b [$];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // One cycle: drive both clients, check acks and any returning reads at the
    // falling edge, book the expected effect of the acked accesses, then step.
    task automatic cyc(input logic ra, input logic wa, input logic [2:0] aa, input logic [7:0] da,
                       input logic rb, input logic wb, input logic [2:0] ab, input logic [7:0] db,
                       input logic ea, input logic eb);
        logic [7:0] e;
        req_a = ra; we_a = wa; addr_a = aa; wdata_a = da;
        req_b = rb; we_b = wb; addr_b = ab; wdata_b = db;
        @(negedge clk);
        check("ack_a", 32'(ack_a), 32'(ea));
        check("ack_b", 32'(ack_b), 32'(eb));
        check("rvalid_a", 32'(rvalid_a), 32'(q_a.size() != 0));
        if (q_a.size() != 0) begin
            e = q_a.pop_front();
            check("rdata_a", 32'(rdata_a), 32'(e));
        end
        check("rvalid_b", 32'(rvalid_b), 32'(q_b.size() != 0));
        if (q_b.size() != 0) begin
            e = q_b.pop_front();
            check("rdata_b", 32'(rdata_b), 32'(e));
        end
        if (ea && ra && !wa) q_a.push_back(ref_mem[aa]);
        if (eb && rb && !wb) q_b.push_back(ref_mem[ab]);
        if (ea && ra && wa) ref_mem[aa] = da;
        if (eb && rb && wb) ref_mem[ab] = db;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc('0, '0, '0, '0, '0, '0, '0, '0, '0, '0);
    endtask

    // Walk the four clear cycles after rst is released, checking the drive.
    task automatic init_walk();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("init_busy", 32'(busy), 1);
            check("init_we", 32'({ram_we_a, ram_we_b}), 3);
            check("init_addr_a", 32'(ram_addr_a), 32'(2 * i));
            check("init_addr_b", 32'(ram_addr_b), 32'(2 * i + 1));
            check("init_din", 32'({ram_din_a, ram_din_b}), 0);
            @(posedge clk);
            #1;
        end
        check("busy_after_init", 32'(busy), 0);
        for (int i = 0; i < 8; i++) ref_mem[i] = 8'h00;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int ka, kb;
        logic win_b;

        rst = 1'b1;
        req_a = 1'b1; req_b = 1'b1; we_a = 1'b0; we_b = 1'b0;
        addr_a = '0; addr_b = '0; wdata_a = '0; wdata_b = '0;
        repeat (2) @(posedge clk);
        #1;
        // Reset state, with requests pending to show they are not acked.
        check("rst_busy", 32'(busy), 1);
        check("rst_ack", 32'({ack_a, ack_b}), 0);
        check("rst_rvalid", 32'({rvalid_a, rvalid_b}), 0);
        check("rst_coll_cnt", 32'(coll_cnt), 0);
        check("rst_ram_we", 32'({ram_we_a, ram_we_b}), 3);
        check("rst_ram_addr_a", 32'(ram_addr_a), 0);
        check("rst_ram_addr_b", 32'(ram_addr_b), 1);
        check("rst_ram_din", 32'({ram_din_a, ram_din_b}), 0);
        req_a = 1'b0; req_b = 1'b0;
        rst = 1'b0;
        init_walk();

        // Every address reads back cleared.
        for (int i = 0; i < 4; i++)
            cyc(1, 0, 3'(2 * i), '0, 1, 0, 3'(2 * i + 1), '0, 1, 1);
        idle();

        // Independent writes, then cross reads.
        cyc(1, 1, 3'd3, 8'h5A, 1, 1, 3'd6, 8'hC3, 1, 1);
        cyc(1, 0, 3'd6, '0, 1, 0, 3'd3, '0, 1, 1);
        idle();

        // Write/read collision, A has priority; B's read follows with new data.
        cyc(1, 1, 3'd2, 8'h11, 1, 0, 3'd2, '0, 1, 0);
        check("coll_cnt_first", 32'(coll_cnt), 1);
        cyc(0, 0, '0, '0, 1, 0, 3'd2, '0, 0, 1);
        idle();

        // Persistent write/write conflict: B holds priority now, wins alternate.
        ka = 0; kb = 0;
        for (int c = 0; c < 6; c++) begin
            win_b = (c % 2 == 0);
            cyc(1, 1, 3'd5, 8'(8'hA0 + ka), 1, 1, 3'd5, 8'(8'hB0 + kb), !win_b, win_b);
            if (win_b) kb++;
            else       ka++;
        end
        check("coll_cnt_after_ww", 32'(coll_cnt), 7);
        cyc(1, 0, 3'd5, '0, 0, 0, '0, '0, 1, 0);
        idle();

        // Same-address reads are not a collision.
        cyc(1, 0, 3'd4, '0, 1, 0, 3'd4, '0, 1, 1);
        idle();
        check("coll_cnt_rr", 32'(coll_cnt), 7);

        // Drive the counter well past saturation.
        for (int c = 0; c < 300; c++) begin
            win_b = (c % 2 == 0);
            cyc(1, 1, 3'd0, 8'(c), 1, 1, 3'd0, 8'(c + 1), !win_b, win_b);
        end
        check("coll_cnt_sat", 32'(coll_cnt), 255);
        idle();
        check("coll_cnt_sat_hold", 32'(coll_cnt), 255);

        // Reset right after an acked read: its rvalid must never appear.
        cyc(1, 0, 3'd3, '0, 0, 0, '0, '0, 1, 0);
        rst = 1'b1;
        req_a = 1'b0;
        q_a.delete();
        @(negedge clk);
        check("midrst_rvalid_a", 32'(rvalid_a), 0);
        check("midrst_busy", 32'(busy), 1);
        check("midrst_coll_cnt", 32'(coll_cnt), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        init_walk();
        cyc(1, 0, 3'd3, '0, 1, 0, 3'd6, '0, 1, 1);
        idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
